// File: rtl/dice_ram_pkg.sv
// Shared constants and helpers for the banked DICE RAM: address split into
// bank/row, bank and row width derivations, and the round-robin pick.
package dice_ram_pkg;

  localparam int BYTE_W        = 8;
  localparam int MAX_PORTS     = 32;
  localparam int MAX_PORT_BITS = 5;
  localparam int DEF_DEPTH     = 1024;
  localparam int DEF_NUM_BANKS = 4;
  localparam int BANK_BITS     = (DEF_NUM_BANKS > 1) ? $clog2(DEF_NUM_BANKS) : 0;
  localparam int ROW_BITS      = $clog2(DEF_DEPTH / DEF_NUM_BANKS);

  function automatic int be_width(input int data_width);
    return data_width / BYTE_W;
  endfunction

  function automatic int bank_bits(input int num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 0;
  endfunction

  // Width of an index register; never zero so a single bank/port still has a signal.
  function automatic int index_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned bank_sel(input logic [31:0] addr, input int nbits);
    return int'(addr & ((32'd1 << nbits) - 32'd1));
  endfunction

  function automatic int unsigned row_sel(input logic [31:0] addr, input int nbits);
    return int'(addr >> nbits);
  endfunction

  // First requesting port at or after ptr, wrapping; -1 when nobody requests.
  function automatic int rr_pick(input logic [MAX_PORTS-1:0] mask, input int ptr,
                                 input int num_ports);
    int pick;
    int idx;
    pick = -1;
    idx  = 0;
    for (int k = 0; k < MAX_PORTS; k++) begin
      if (k < num_ports) begin
        idx = (ptr + k) % num_ports;
        if (pick < 0 && mask[MAX_PORT_BITS'(idx)]) pick = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/dice_ram_bank.sv
// One single-port 1RW bank: byte-enable write, registered read.
// Contents are never reset.
module dice_ram_bank
  import dice_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ROWS       = 256,
  parameter int ROW_W      = 8
) (
  input  logic                    clk,
  input  logic                    en_i,
  input  logic                    we_i,
  input  logic [ROW_W-1:0]        row_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  localparam int BE_W = be_width(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [ROWS];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int i = 0; i < BE_W; i++) begin
          if (be_i[i]) mem_q[row_i][i*BYTE_W +: BYTE_W] <= wdata_i[i*BYTE_W +: BYTE_W];
        end
      end else begin
        rdata_q <= mem_q[row_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dice_ram_banked.sv
// Multi-port, word-interleaved multi-bank RAM with per-bank round-robin arbitration.
// Define DICE_RAM_BANKED_OUTREG_EN to add an output register stage (read latency 2).
module dice_ram_banked
  import dice_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int NUM_BANKS  = DEF_NUM_BANKS,
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_PORTS-1:0]                  req_valid,
  output logic [NUM_PORTS-1:0]                  req_ready,
  input  logic [NUM_PORTS-1:0]                  req_we,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  req_wdata,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0] req_be,
  output logic [NUM_PORTS-1:0]                  rsp_valid,
  output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  rsp_rdata
);

  localparam int BANK_W = bank_bits(NUM_BANKS);
  localparam int BSEL_W = index_bits(NUM_BANKS);
  localparam int ROWS   = DEPTH / NUM_BANKS;
  localparam int ROW_W  = index_bits(ROWS);
  localparam int PORT_W = index_bits(NUM_PORTS);
  localparam int BE_W   = be_width(DATA_WIDTH);

  logic [NUM_PORTS-1:0][BSEL_W-1:0] port_bank;
  logic [NUM_PORTS-1:0][ROW_W-1:0]  port_row;

  logic [MAX_PORTS-1:0]             arb_mask [NUM_BANKS];
  int                               arb_pick [NUM_BANKS];
  logic [NUM_BANKS-1:0]             gnt_v;
  logic [NUM_BANKS-1:0][PORT_W-1:0] gnt_port;
  logic [NUM_BANKS-1:0][PORT_W-1:0] rr_q, rr_d;

  logic [NUM_BANKS-1:0]             bank_we;
  logic [ROW_W-1:0]                 bank_row   [NUM_BANKS];
  logic [DATA_WIDTH-1:0]            bank_wdata [NUM_BANKS];
  logic [BE_W-1:0]                  bank_be    [NUM_BANKS];
  logic [DATA_WIDTH-1:0]            bank_rdata [NUM_BANKS];

  logic [NUM_PORTS-1:0]                 rd_v_d, rd_v_q;
  logic [NUM_PORTS-1:0][BSEL_W-1:0]     rd_tag_q;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] s1_data;

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_bank[p] = BSEL_W'(bank_sel(32'(req_addr[p]), BANK_W));
      port_row[p]  = ROW_W'(row_sel(32'(req_addr[p]), BANK_W));
    end
  end

  // Each bank grants the first valid port at or after its pointer; the pointer
  // moves past the winner so a port that keeps losing wins within NUM_PORTS cycles.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      arb_mask[b] = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        arb_mask[b][p] = req_valid[p] && (port_bank[p] == BSEL_W'(b));
      end
      arb_pick[b] = rr_pick(arb_mask[b], int'(rr_q[b]), NUM_PORTS);
      gnt_v[b]    = rst_n && (arb_pick[b] >= 0);
      gnt_port[b] = (arb_pick[b] >= 0) ? PORT_W'(arb_pick[b]) : '0;
      rr_d[b]     = gnt_v[b] ? PORT_W'((arb_pick[b] + 1) % NUM_PORTS) : rr_q[b];
    end
  end

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // a stalled requester keeps valid and its payload stable until then. Responses
  // have no backpressure: rsp_valid pulses once per accepted read.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      req_ready[p] = rst_n && req_valid[p] && gnt_v[port_bank[p]]
                     && (gnt_port[port_bank[p]] == PORT_W'(p));
      rd_v_d[p]    = req_ready[p] && !req_we[p];
    end
  end

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_we[b]    = req_we[gnt_port[b]];
      bank_row[b]   = port_row[gnt_port[b]];
      bank_wdata[b] = req_wdata[gnt_port[b]];
      bank_be[b]    = req_be[gnt_port[b]];
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    dice_ram_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .ROWS       (ROWS),
      .ROW_W      (ROW_W)
    ) u_bank (
      .clk     (clk),
      .en_i    (gnt_v[b]),
      .we_i    (bank_we[b]),
      .row_i   (bank_row[b]),
      .wdata_i (bank_wdata[b]),
      .be_i    (bank_be[b]),
      .rdata_o (bank_rdata[b])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_q     <= '0;
      rd_v_q   <= '0;
      rd_tag_q <= '0;
    end else begin
      rr_q     <= rr_d;
      rd_v_q   <= rd_v_d;
      rd_tag_q <= port_bank;
    end
  end

  // The tag remembers which bank holds each port's read data this cycle.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      s1_data[p] = bank_rdata[rd_tag_q[p]];
    end
  end

`ifdef DICE_RAM_BANKED_OUTREG_EN
  logic [NUM_PORTS-1:0]                 out_v_q;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] out_data_q, out_data_d;

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      out_data_d[p] = rd_v_q[p] ? s1_data[p] : out_data_q[p];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_v_q    <= '0;
      out_data_q <= '0;
    end else begin
      out_v_q    <= rd_v_q;
      out_data_q <= out_data_d;
    end
  end

  assign rsp_valid = out_v_q & {NUM_PORTS{rst_n}};
  assign rsp_rdata = out_data_q;
`else
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] hold_q, hold_d;

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      hold_d[p]    = rd_v_q[p] ? s1_data[p] : hold_q[p];
      rsp_rdata[p] = hold_d[p];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) hold_q <= '0;
    else        hold_q <= hold_d;
  end

  // Gating with rst_n drops a read that would surface in the reset cycle itself.
  assign rsp_valid = rd_v_q & {NUM_PORTS{rst_n}};
`endif

endmodule

// File: tb/tb_dice_ram_banked.sv
// Directed bench for dice_ram_banked: drivers push expected read data into
// per-port queues, a negedge monitor pops and compares on rsp_valid.
module tb_dice_ram_banked;

  localparam int NP = 2;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int BW = 4;
`ifdef DICE_RAM_BANKED_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NP-1:0]          req_valid = '0;
  logic [NP-1:0]          req_ready;
  logic [NP-1:0]          req_we = '0;
  logic [NP-1:0][AW-1:0]  req_addr = '0;
  logic [NP-1:0][DW-1:0]  req_wdata = '0;
  logic [NP-1:0][BW-1:0]  req_be = '0;
  logic [NP-1:0]          rsp_valid;
  logic [NP-1:0][DW-1:0]  rsp_rdata;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  int            due_q0[$];
  int            due_q1[$];
  logic [DW-1:0] last_val [NP];

  dice_ram_banked dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int p, input logic [DW-1:0] e, input int d);
    if (p == 0) begin
      exp_q0.push_back(e);
      due_q0.push_back(d);
    end else begin
      exp_q1.push_back(e);
      due_q1.push_back(d);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_port(input int p, input logic v, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [BW-1:0] be);
    req_valid[p] = v;
    req_we[p]    = we;
    req_addr[p]  = a;
    req_wdata[p] = d;
    req_be[p]    = be;
  endtask

  task automatic tick(input logic [DW-1:0] e0, input logic [DW-1:0] e1, output logic [NP-1:0] rdy);
    @(negedge clk);
    rdy = req_ready;
    if (req_valid[0] && req_ready[0] && !req_we[0]) push_exp(0, e0, cyc + LAT);
    if (req_valid[1] && req_ready[1] && !req_we[1]) push_exp(1, e1, cyc + LAT);
    @(posedge clk);
    #1;
  endtask

  task automatic op(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                    input logic [BW-1:0] be, input logic [DW-1:0] e);
    logic [NP-1:0] rdy;
    bit done;
    done = 0;
    set_port(p, 1'b1, we, a, d, be);
    for (int i = 0; i < 8 && !done; i++) begin
      tick(e, e, rdy);
      if (rdy[p]) done = 1;
    end
    req_valid[p] = 1'b0;
    check($sformatf("op_accept_p%0d_a%0h", p, a), done, 1);
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    set_port(0, 1'b1, 1'b0, 10'h004, '0, '0);
    set_port(1, 1'b1, 1'b1, 10'h008, 32'hFFFF_FFFF, 4'hF);
    exp_q0.delete(); due_q0.delete();
    exp_q1.delete(); due_q1.delete();
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      if (i > 0) check("rst_rsp_rdata", rsp_rdata, 0);
      @(posedge clk);
      #1;
      last_val[0] = '0;
      last_val[1] = '0;
    end
    req_valid = '0;
    rst_n = 1'b1;
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic mon_port(input int p);
    logic [DW-1:0] e;
    int d;
    bit have;
    have = 0;
    e = '0;
    d = 0;
    if (rsp_valid[p]) begin
      if (p == 0 && exp_q0.size() > 0) begin
        e = exp_q0.pop_front(); d = due_q0.pop_front(); have = 1;
      end else if (p == 1 && exp_q1.size() > 0) begin
        e = exp_q1.pop_front(); d = due_q1.pop_front(); have = 1;
      end
      if (!have) begin
        check($sformatf("rsp%0d_unexpected", p), rsp_valid[p], 0);
      end else begin
        check($sformatf("rsp%0d_data", p), rsp_rdata[p], e);
        check($sformatf("rsp%0d_cycle", p), cyc, d);
        last_val[p] = e;
      end
    end else if (rst_n) begin
      check($sformatf("rsp%0d_hold", p), rsp_rdata[p], last_val[p]);
    end
  endtask

  always @(negedge clk) begin
    mon_port(0);
    mon_port(1);
  end

  // Requester rule: a stalled request stays valid and unchanged.
  logic [NP-1:0]         pv = '0, pr = '0, pwe = '0;
  logic [NP-1:0][AW-1:0] pa = '0;
  logic [NP-1:0][DW-1:0] pd = '0;
  logic [NP-1:0][BW-1:0] pb = '0;
  logic                  prst = 1'b0;
  always @(negedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (rst_n && prst && pv[p] && !pr[p]) begin
        if (!(req_valid[p] && req_we[p] == pwe[p] && req_addr[p] == pa[p]
              && req_wdata[p] == pd[p] && req_be[p] == pb[p]))
          $error("port %0d changed a stalled request", p);
      end
    end
    pv = req_valid; pr = req_ready; pwe = req_we;
    pa = req_addr; pd = req_wdata; pb = req_be; prst = rst_n;
  end

  // ---------------- directed stimulus ----------------
  initial begin
    logic [NP-1:0] rdy;
    last_val[0] = '0;
    last_val[1] = '0;

    do_reset(3);

    // Basic write then read on port 0.
    op(0, 1'b1, 10'h005, 32'hDEAD_BEEF, 4'hF, '0);
    op(0, 1'b0, 10'h005, '0, '0, 32'hDEAD_BEEF);

    // Byte enables on port 1, including an all-zero enable write.
    op(1, 1'b1, 10'h009, 32'h1122_3344, 4'hF, '0);
    op(1, 1'b1, 10'h009, 32'hAABB_CCDD, 4'h5, '0);
    op(1, 1'b0, 10'h009, '0, '0, 32'h11BB_33DD);
    op(1, 1'b1, 10'h009, 32'hFFFF_FFFF, 4'h0, '0);
    op(1, 1'b0, 10'h009, '0, '0, 32'h11BB_33DD);

    // Parallel reads to different banks.
    op(0, 1'b1, 10'h000, 32'hA0A0_A0A0, 4'hF, '0);
    op(1, 1'b1, 10'h001, 32'hB1B1_B1B1, 4'hF, '0);
    set_port(0, 1'b1, 1'b0, 10'h000, '0, '0);
    set_port(1, 1'b1, 1'b0, 10'h001, '0, '0);
    tick(32'hA0A0_A0A0, 32'hB1B1_B1B1, rdy);
    check("parallel_ready", rdy, 2'b11);
    req_valid = '0;

    // Conflict on bank 2: the two writes leave rr[2] back at port 0.
    op(0, 1'b1, 10'h002, 32'hC2C2_C2C2, 4'hF, '0);
    op(1, 1'b1, 10'h006, 32'hC6C6_C6C6, 4'hF, '0);
    set_port(0, 1'b1, 1'b0, 10'h002, '0, '0);
    set_port(1, 1'b1, 1'b0, 10'h006, '0, '0);
    for (int i = 0; i < 4; i++) begin
      tick(32'hC2C2_C2C2, 32'hC6C6_C6C6, rdy);
      check($sformatf("conflict_gnt%0d", i), rdy, (i % 2 == 0) ? 2'b01 : 2'b10);
    end
    req_valid[1] = 1'b0;
    tick(32'hC2C2_C2C2, 32'hC6C6_C6C6, rdy);
    check("conflict_tail", rdy, 2'b01);
    req_valid = '0;

    // Back-to-back reads on port 0 across all four banks.
    op(0, 1'b1, 10'h003, 32'hD3D3_D3D3, 4'hF, '0);
    set_port(0, 1'b1, 1'b0, 10'h000, '0, '0);
    tick(32'hA0A0_A0A0, '0, rdy); check("b2b_0", rdy, 2'b01);
    set_port(0, 1'b1, 1'b0, 10'h005, '0, '0);
    tick(32'hDEAD_BEEF, '0, rdy); check("b2b_1", rdy, 2'b01);
    set_port(0, 1'b1, 1'b0, 10'h002, '0, '0);
    tick(32'hC2C2_C2C2, '0, rdy); check("b2b_2", rdy, 2'b01);
    set_port(0, 1'b1, 1'b0, 10'h003, '0, '0);
    tick(32'hD3D3_D3D3, '0, rdy); check("b2b_3", rdy, 2'b01);

    // Write then read the same word on the next cycle.
    set_port(0, 1'b1, 1'b1, 10'h00C, 32'h1234_5678, 4'hF);
    tick('0, '0, rdy); check("raw_write", rdy, 2'b01);
    set_port(0, 1'b1, 1'b0, 10'h00C, '0, '0);
    tick(32'h1234_5678, '0, rdy); check("raw_read", rdy, 2'b01);
    req_valid = '0;
    repeat (3) tick('0, '0, rdy);

    // Reset while a read is in flight; memory contents survive.
    set_port(0, 1'b1, 1'b0, 10'h005, '0, '0);
    tick(32'hDEAD_BEEF, '0, rdy); check("midrst_accept", rdy, 2'b01);
    do_reset(3);
    op(0, 1'b0, 10'h005, '0, '0, 32'hDEAD_BEEF);
    op(1, 1'b0, 10'h009, '0, '0, 32'h11BB_33DD);

    // Pointer cleared by reset: port 0 wins the first bank-2 conflict.
    set_port(0, 1'b1, 1'b0, 10'h002, '0, '0);
    set_port(1, 1'b1, 1'b0, 10'h006, '0, '0);
    tick(32'hC2C2_C2C2, 32'hC6C6_C6C6, rdy);
    check("post_rst_gnt", rdy, 2'b01);
    req_valid[0] = 1'b0;
    tick(32'hC2C2_C2C2, 32'hC6C6_C6C6, rdy);
    check("post_rst_p1", rdy, 2'b10);
    req_valid = '0;

    // Drain outstanding responses with a bounded wait.
    for (int i = 0; i < 10 && (exp_q0.size() + exp_q1.size()) > 0; i++) tick('0, '0, rdy);
    check("drain_q0", exp_q0.size(), 0);
    check("drain_q1", exp_q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
